fb_pixel_fetcher: RTL and testbench
===================================

Name: fb_pixel_fetcher

Overview:
- Parametrised framebuffer fetch engine in the clk50M domain, sitting between the VGA pixel pipeline and the SDRAM memory controller.
- Prefetches framebuffer words in bursts into a word FIFO and unpacks them into pixels on a pixel-clock-enable strobe.
- Arbitrates a single-word write port, used by the pattern writer or CPU, against display reads.
- Replaces the fixed 4-pixel ping-pong scheme with configurable pixel width, burst length, FIFO depth and frame size.

Parameters:
- ADDR_W, 24, memory word address width
- WORD_W, 16, memory data word width
- PIX_W, 4, bits per pixel; WORD_W % PIX_W == 0; PPW = WORD_W/PIX_W
- BURST, 4, words per read request (1..256)
- FIFO_DEPTH, 32, FIFO words; power of two, >= 2*BURST
- FRAME_WORDS, 19200, words per frame (76800 pixels at 4 bpp)
- LOW_WATER, 8, FIFO level below which reads pre-empt pending writes

Ports:
- clk50M in 1: clock
- nreset in 1: synchronous active-low reset
- vint in 1: frame-start pulse, one cycle
- visible in 1: video is in the visible area
- pix_ce in 1: one-cycle strobe per pixel consumed (25 MHz rate)
- pix_out out PIX_W: current pixel
- underrun out 1: sticky, FIFO was empty on a visible pix_ce
- wr_req in 1: write request, level, held until wr_ack
- wr_addr in ADDR_W: write word address
- wr_data in WORD_W: write data
- wr_ack out 1: one-cycle pulse when the memory controller accepts the write
- mem_request out 1: request to the memory controller
- mem_nwe out 1: 1 = read, 0 = write
- mem_addr out ADDR_W: start word address
- mem_size out 9: words in the transfer (BURST for reads, 1 for writes)
- mem_wdata out WORD_W: write data
- mem_rvalid in 1: one read word valid this cycle
- mem_rdata in WORD_W: read word
- mem_data_ready in 1: read burst complete
- mem_save_ready in 1: write complete

Behaviour:
- Reset (nreset sampled low on a clk50M edge):
  - state IDLE; FIFO empty; fetch_addr 0; pixel index 0.
  - pix_out 0, underrun 0, wr_ack 0, mem_request 0, mem_nwe 1, mem_addr 0, mem_size 0, mem_wdata 0.
- Reset mid-transfer abandons the transfer immediately; the memory controller is reset by the same nreset.
- FSM IDLE, evaluated each cycle in priority order:
  1. flush_pend: clear the FIFO, set fetch_addr to 0, clear flush_pend, stay in IDLE.
  2. Reads have priority: FIFO level < LOW_WATER and fetch_addr < FRAME_WORDS -> go to RD.
  3. Writes next: wr_req -> go to WR.
  4. Otherwise read if free space >= BURST and fetch_addr < FRAME_WORDS -> go to RD.
- Entering RD:
  - mem_request=1, mem_nwe=1, mem_addr=fetch_addr, mem_size=min(BURST, FRAME_WORDS-fetch_addr).
  - Each mem_rvalid pushes mem_rdata into the FIFO, unless flush_pend is set, in which case the word is dropped.
  - Space is reserved at issue, so the FIFO never overflows. A mem_rvalid while full is a protocol error and is dropped.
  - On mem_data_ready: mem_request=0, fetch_addr += mem_size, go to IDLE.
- Entering WR:
  - mem_request=1, mem_nwe=0, mem_addr=wr_addr, mem_wdata=wr_data, mem_size=1.
  - On mem_save_ready: mem_request=0, wr_ack=1 for one cycle, go to IDLE. wr_req is not re-sampled in the ack cycle.
- Request rules: mem_request rises at most once per transfer and drops in the cycle after the ready pulse. Address, size and data are stable while it is high.
- vint handling:
  - vint sets flush_pend and clears underrun.
  - If the FSM is in RD, the burst completes and its data is discarded.
  - vint coincident with mem_data_ready: flush still applies.
- Pixel path, on each pix_ce with visible=1:
  - If a current word is loaded: pix_out = word[idx*PIX_W +: PIX_W], LSB pixel first.
  - idx increments; at idx==PPW-1 the FIFO is popped and idx wraps to 0.
  - Latency: pix_out updates on the clk50M edge where pix_ce is sampled.
  - Current word unavailable (FIFO empty): pix_out=0, underrun=1, idx unchanged.
- pix_ce with visible=0: no effect. pix_out holds its last value.
- Push and pop in the same cycle: the level is unchanged.
- A flush also resets idx to 0.

Optional Feature:
- FB_FETCH_STATS_EN defined: adds output underrun_count [15:0].
  - Increments on every underrun event and saturates at 16'hFFFF.
  - Cleared by nreset only; it is not cleared by vint.
- FB_FETCH_STATS_EN undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset with nreset=0 for 3 cycles -> all outputs at their reset values; first read issued with mem_addr=0, mem_size=4.
- Memory model returns words 16'h3210, 16'h7654, then a pix_ce train with visible=1 -> pix_out sequence 0,1,2,3,4,5,6,7; underrun stays 0.
- FRAME_WORDS=6, BURST=4 -> requests (addr 0, size 4) then (addr 4, size 2); no further read until vint.
- wr_req with wr_addr=100, wr_data=16'h1111 while FIFO level >= LOW_WATER -> WR issued with mem_nwe=0, mem_size=1; wr_ack pulses once after mem_save_ready.
- vint mid-burst at the 2nd of 4 words -> remaining words dropped, FIFO empty, next request at addr 0.
- Stop the memory model and keep pix_ce running -> underrun=1, pix_out=0; with FB_FETCH_STATS_EN, underrun_count equals the number of starved strobes, and underrun clears on vint.

Source files
------------

// File: rtl/fb_pixel_fetcher_if.sv
// Memory-controller bus between fb_pixel_fetcher (master) and the SDRAM controller (slave).
interface fb_pixel_fetcher_if #(
    parameter int ADDR_W = 24,
    parameter int WORD_W = 16
);
    logic              mem_request;
    logic              mem_nwe;
    logic [ADDR_W-1:0] mem_addr;
    logic [8:0]        mem_size;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_data_ready;
    logic              mem_save_ready;

    modport master (
        output mem_request, mem_nwe, mem_addr, mem_size, mem_wdata,
        input  mem_rvalid, mem_rdata, mem_data_ready, mem_save_ready
    );

    modport slave (
        input  mem_request, mem_nwe, mem_addr, mem_size, mem_wdata,
        output mem_rvalid, mem_rdata, mem_data_ready, mem_save_ready
    );
endinterface

// File: rtl/fb_pixel_fetcher.sv
// Framebuffer fetch engine: burst prefetch into a word FIFO, pixel unpack on pix_ce, single-word write port.
// Optional FB_FETCH_STATS_EN adds a saturating underrun_count output.
//
// state | meaning
// IDLE  | arbitrate: flush, low-water read, write, opportunistic read
// RD    | read burst outstanding, words pushed on mem_rvalid
// WR    | single-word write outstanding
module fb_pixel_fetcher #(
    parameter int ADDR_W      = 24,
    parameter int WORD_W      = 16,
    parameter int PIX_W       = 4,
    parameter int BURST       = 4,
    parameter int FIFO_DEPTH  = 32,
    parameter int FRAME_WORDS = 19200,
    parameter int LOW_WATER   = 8
) (
    input  logic              clk50M,
    input  logic              nreset,
    input  logic              vint,
    input  logic              visible,
    input  logic              pix_ce,
    output logic [PIX_W-1:0]  pix_out,
    output logic              underrun,
`ifdef FB_FETCH_STATS_EN
    output logic [15:0]       underrun_count,
`endif
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ack,
    fb_pixel_fetcher_if.master mem
);
    localparam int PPW = WORD_W / PIX_W;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state, state_nx;

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, level, free_space;
    logic [ADDR_W-1:0] fetch_addr, remain;
    logic [8:0]        rd_size;
    logic [IW-1:0]     idx;
    logic [WORD_W-1:0] head;
    logic              flush_pend, fifo_empty, fifo_full, frame_left;
    logic              push, pop, pix_take, starve;
    logic              issue_rd, issue_wr, done_rd, done_wr, do_flush;

    assign level      = wr_ptr - rd_ptr;
    assign free_space = (AW+1)'(FIFO_DEPTH) - level;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == (AW+1)'(FIFO_DEPTH));
    assign frame_left = (fetch_addr < ADDR_W'(FRAME_WORDS));
    assign remain     = ADDR_W'(FRAME_WORDS) - fetch_addr;
    assign rd_size    = (remain < ADDR_W'(BURST)) ? 9'(remain) : 9'(BURST);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign pix_take = pix_ce & visible;
    assign starve   = pix_take & fifo_empty;
    assign pop      = pix_take & ~fifo_empty & (idx == IW'(PPW-1));
    // Words arriving after a vint belong to the old frame and are discarded.
    assign push     = (state == RD) & mem.mem_rvalid & ~flush_pend & ~fifo_full;

    always_ff @(posedge clk50M) begin
        if (!nreset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        done_rd  = 1'b0;
        done_wr  = 1'b0;
        do_flush = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pend) begin
                    do_flush = 1'b1;
                end else if (level < (AW+1)'(LOW_WATER) && frame_left) begin
                    issue_rd = 1'b1;
                    state_nx = RD;
                end else if (wr_req && !wr_ack) begin
                    // wr_req is still held by the master during the ack cycle
                    issue_wr = 1'b1;
                    state_nx = WR;
                end else if (free_space >= (AW+1)'(BURST) && frame_left) begin
                    issue_rd = 1'b1;
                    state_nx = RD;
                end
            end
            RD: if (mem.mem_data_ready) begin
                done_rd  = 1'b1;
                state_nx = IDLE;
            end
            WR: if (mem.mem_save_ready) begin
                done_wr  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= mem.mem_rdata;
    end

    always_ff @(posedge clk50M) begin
        if (!nreset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fetch_addr      <= '0;
            idx             <= '0;
            flush_pend      <= 1'b0;
            pix_out         <= '0;
            underrun        <= 1'b0;
            wr_ack          <= 1'b0;
            mem.mem_request <= 1'b0;
            mem.mem_nwe     <= 1'b1;
            mem.mem_addr    <= '0;
            mem.mem_size    <= '0;
            mem.mem_wdata   <= '0;
        end else begin
            wr_ack <= done_wr;

            if (issue_rd) begin
                mem.mem_request <= 1'b1;
                mem.mem_nwe     <= 1'b1;
                mem.mem_addr    <= fetch_addr;
                mem.mem_size    <= rd_size;
            end
            if (issue_wr) begin
                mem.mem_request <= 1'b1;
                mem.mem_nwe     <= 1'b0;
                mem.mem_addr    <= wr_addr;
                mem.mem_wdata   <= wr_data;
                mem.mem_size    <= 9'd1;
            end
            if (done_rd || done_wr) mem.mem_request <= 1'b0;

            if (do_flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fetch_addr <= '0;
                idx        <= '0;
                flush_pend <= 1'b0;
            end else begin
                if (done_rd) fetch_addr <= fetch_addr + ADDR_W'(mem.mem_size);
                if (push)    wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                if (pix_take && !fifo_empty)
                    idx <= (idx == IW'(PPW-1)) ? '0 : idx + IW'(1);
            end
            if (vint) flush_pend <= 1'b1;

            if (pix_take)
                pix_out <= fifo_empty ? '0 : head[int'(idx)*PIX_W +: PIX_W];

            if (vint)   underrun <= 1'b0;
            if (starve) underrun <= 1'b1;
        end
    end

`ifdef FB_FETCH_STATS_EN
    always_ff @(posedge clk50M) begin
        if (!nreset)
            underrun_count <= '0;
        else if (starve && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_fb_pixel_fetcher.sv
// Directed bench for fb_pixel_fetcher with a small behavioural memory controller.
module tb_fb_pixel_fetcher;
    localparam int ADDR_W = 24;
    localparam int WORD_W = 16;
    localparam int PIX_W  = 4;

    logic clk50M, nreset;
    logic vint_tb, vint_model, vint;
    logic visible, pix_ce, underrun, wr_req, wr_ack;
    logic [PIX_W-1:0]  pix_out;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
`ifdef FB_FETCH_STATS_EN
    logic [15:0] underrun_count;
`endif

    fb_pixel_fetcher_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    assign vint = vint_tb | vint_model;

    fb_pixel_fetcher #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .PIX_W(PIX_W), .BURST(4),
        .FIFO_DEPTH(8), .FRAME_WORDS(6), .LOW_WATER(4)
    ) dut (
        .clk50M(clk50M), .nreset(nreset), .vint(vint), .visible(visible),
        .pix_ce(pix_ce), .pix_out(pix_out), .underrun(underrun),
`ifdef FB_FETCH_STATS_EN
        .underrun_count(underrun_count),
`endif
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .mem(bus)
    );

    initial clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    int n_assert = 0;
    int n_fail   = 0;

    // memory model state
    logic        mem_en = 1'b0;
    logic        hold   = 1'b0;
    int          vint_on_word = -1;
    int          rd_log_addr[$];
    int          rd_log_size[$];
    int          wr_log = 0;
    int          m_addr, m_size;
    logic [15:0] fm [0:7];

    initial begin
        fm[0] = 16'h3210; fm[1] = 16'h7654; fm[2] = 16'hBA98; fm[3] = 16'hFEDC;
        fm[4] = 16'h1357; fm[5] = 16'h2468; fm[6] = 16'h0000; fm[7] = 16'h0000;
        vint_model = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_data_ready = 1'b0;
        bus.mem_save_ready = 1'b0;
        forever begin
            @(negedge clk50M);
            if (bus.mem_request && mem_en && !hold) begin
                if (bus.mem_nwe) begin
                    m_addr = int'(bus.mem_addr);
                    m_size = int'(bus.mem_size);
                    rd_log_addr.push_back(m_addr);
                    rd_log_size.push_back(m_size);
                    for (int i = 0; i < m_size; i++) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = fm[(m_addr + i) % 8];
                        if (i == vint_on_word) begin
                            vint_model = 1'b1;
                            hold = 1'b1;
                        end
                        @(negedge clk50M);
                        bus.mem_rvalid = 1'b0;
                        vint_model = 1'b0;
                    end
                    bus.mem_data_ready = 1'b1;
                    @(negedge clk50M);
                    bus.mem_data_ready = 1'b0;
                end else begin
                    wr_log++;
                    @(negedge clk50M);
                    @(negedge clk50M);
                    bus.mem_save_ready = 1'b1;
                    @(negedge clk50M);
                    bus.mem_save_ready = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             vis;
        logic             ce;
        logic [PIX_W-1:0] pix;
        logic             und;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic vis, input logic ce, input logic [PIX_W-1:0] pix, input logic und);
        vec_t v;
        v.vis = vis; v.ce = ce; v.pix = pix; v.und = und;
        vecs.push_back(v);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_cnt;
        logic seen;

        // 6 words: 3210 7654 BA98 FEDC 1357 2468, LSB pixel first
        add(1,1,4'h0,0); add(1,1,4'h1,0); add(1,1,4'h2,0); add(1,1,4'h3,0);
        add(0,1,4'h3,0); add(1,1,4'h4,0); add(1,1,4'h5,0); add(1,1,4'h6,0);
        add(1,1,4'h7,0); add(1,0,4'h7,0); add(1,1,4'h8,0); add(1,1,4'h9,0);
        add(1,1,4'hA,0); add(1,1,4'hB,0); add(1,1,4'hC,0); add(1,1,4'hD,0);
        add(1,1,4'hE,0); add(1,1,4'hF,0); add(1,1,4'h7,0); add(1,1,4'h5,0);
        add(1,1,4'h3,0); add(1,1,4'h1,0); add(1,1,4'h8,0); add(1,1,4'h6,0);
        add(1,1,4'h4,0); add(1,1,4'h2,0); add(1,1,4'h0,1); add(1,1,4'h0,1);
        add(0,1,4'h0,1);

        nreset = 1'b0; vint_tb = 1'b0; visible = 1'b0; pix_ce = 1'b0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) tick();
        check("rst_pix_out", pix_out, 0);
        check("rst_underrun", underrun, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_mem_request", bus.mem_request, 0);
        check("rst_mem_nwe", bus.mem_nwe, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_size", bus.mem_size, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
`ifdef FB_FETCH_STATS_EN
        check("rst_underrun_count", underrun_count, 0);
`endif

        nreset = 1'b1;
        repeat (3) tick();
        check("first_rd_request", bus.mem_request, 1);
        check("first_rd_nwe", bus.mem_nwe, 1);
        check("first_rd_addr", bus.mem_addr, 0);
        check("first_rd_size", bus.mem_size, 4);

        mem_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            tick();
            if (rd_log_addr.size() == 2 && !bus.mem_request) seen = 1'b1;
        end
        check("frame_fetch_done", seen, 1);
        repeat (10) tick();
        check("frame_rd_count", rd_log_addr.size(), 2);
        if (rd_log_addr.size() >= 2) begin
            check("rd0_addr", rd_log_addr[0], 0);
            check("rd0_size", rd_log_size[0], 4);
            check("rd1_addr", rd_log_addr[1], 4);
            check("rd1_size", rd_log_size[1], 2);
        end

        // write while the FIFO holds 6 words (>= LOW_WATER)
        wr_addr = 24'd100; wr_data = 16'h1111; wr_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (bus.mem_request && !bus.mem_nwe) seen = 1'b1;
        end
        check("wr_issued", seen, 1);
        check("wr_nwe", bus.mem_nwe, 0);
        check("wr_size", bus.mem_size, 1);
        check("wr_addr", bus.mem_addr, 100);
        check("wr_wdata", bus.mem_wdata, 16'h1111);
        ack_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (wr_ack) ack_cnt++;
            else if (ack_cnt > 0) wr_req = 1'b0;
        end
        wr_req = 1'b0;
        check("wr_ack_pulses", ack_cnt, 1);
        check("wr_count", wr_log, 1);
        check("wr_request_dropped", bus.mem_request, 0);

        foreach (vecs[i]) begin
            visible = vecs[i].vis;
            pix_ce  = vecs[i].ce;
            tick();
            pix_ce = 1'b0;
            check($sformatf("vec%0d_pix", i), pix_out, vecs[i].pix);
            check($sformatf("vec%0d_underrun", i), underrun, vecs[i].und);
            tick();
        end
        check("no_read_before_vint", rd_log_addr.size(), 2);
`ifdef FB_FETCH_STATS_EN
        check("underrun_count_2", underrun_count, 2);
`endif

        // new frame; a second vint lands on the 2nd word of the refetch burst
        vint_on_word = 1;
        vint_tb = 1'b1;
        tick();
        vint_tb = 1'b0;
        check("vint_clears_underrun", underrun, 0);
`ifdef FB_FETCH_STATS_EN
        check("count_kept_on_vint", underrun_count, 2);
`endif
        repeat (30) tick();
        check("midburst_rd_count", rd_log_addr.size(), 3);
        if (rd_log_addr.size() >= 3) check("refetch_addr", rd_log_addr[2], 0);
        check("post_flush_request", bus.mem_request, 1);
        check("post_flush_nwe", bus.mem_nwe, 1);
        check("post_flush_addr", bus.mem_addr, 0);
        check("post_flush_size", bus.mem_size, 4);
        check("post_flush_underrun_clear", underrun, 0);
        visible = 1'b1; pix_ce = 1'b1;
        tick();
        pix_ce = 1'b0;
        check("flushed_fifo_pix", pix_out, 0);
        check("flushed_fifo_underrun", underrun, 1);
`ifdef FB_FETCH_STATS_EN
        check("underrun_count_3", underrun_count, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
